// File: rtl/serv_ibus_spiflash.sv
// SERV instruction-bus responder that serves each word fetch with one SPI NOR READ transaction.
// SPI mode 0 with SCK = clk/2; the fetched bytes are assembled little-endian into o_ibus_rdt.
module serv_ibus_spiflash #(
    parameter logic [23:0] FLASH_OFFSET = 24'h000000,
    parameter logic [7:0]  READ_CMD     = 8'h03
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic        o_spi_cs_n,
    output logic        o_spi_sck,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    // Handshake: i_ibus_cyc is a request held high until the one-cycle o_ibus_ack strobe;
    // o_ibus_rdt is valid while o_ibus_ack=1 and holds until the next completed fetch.
    // Dropping i_ibus_cyc before ack abandons the fetch without an ack.

    logic [1:0]  state_q, state_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;
    logic [23:0] faddr;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^{i_ibus_adr[31:24], i_ibus_adr[1:0]};
    assign faddr = {i_ibus_adr[23:2], 2'b00} + FLASH_OFFSET;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        ack_d   = 1'b0;
        rdt_d   = rdt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_ibus_cyc) begin
                    tx_d    = {READ_CMD, faddr};
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    mosi_d  = READ_CMD[7];
                    cnt_d   = 6'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!i_ibus_cyc) begin
                    cs_n_d  = 1'b1;
                    sck_d   = 1'b0;
                    mosi_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    // Falling SCK: sample MISO, present the next MOSI bit (zeros fill in after cmd/addr).
                    sck_d  = 1'b0;
                    rx_d   = {rx_q[30:0], i_spi_miso};
                    tx_d   = {tx_q[30:0], 1'b0};
                    mosi_d = tx_q[30];
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        rdt_d   = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= 32'd0;
            rx_q    <= 32'd0;
            cnt_q   <= 6'd0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ack_q   <= ack_d;
            rdt_q   <= rdt_d;
        end
    end

    assign o_ibus_rdt  = rdt_q;
    assign o_ibus_ack  = ack_q;
    assign o_spi_cs_n  = cs_n_q;
    assign o_spi_sck   = sck_q;
    assign o_spi_mosi  = mosi_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_serv_ibus_spiflash.sv
// Bench for serv_ibus_spiflash: two instances (offset 0 and 0x100000) each talking to a
// behavioural SPI NOR flash; fetched words are checked against a byte-level memory model.
module tb_serv_ibus_spiflash;

    localparam logic [7:0] CMD = 8'h03;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr [2];
    logic [31:0] rdt [2];
    logic [1:0]  dbg [2];
    logic [1:0]  cyc, ack, cs_n, sck, mosi, miso;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mem_seed;

    int          rises [2];
    logic [31:0] seen [2];
    int          spur_rises = 0;
    int          sck_fast = 0;
    int          hi_cnt [2];
    int          last_gap [2];
    int          sck_hi_run [2];

    serv_ibus_spiflash #(.FLASH_OFFSET(24'h000000), .READ_CMD(CMD)) u_dut0 (
        .clk(clk), .i_rst_n(rst_n), .i_ibus_adr(adr[0]), .i_ibus_cyc(cyc[0]),
        .o_ibus_rdt(rdt[0]), .o_ibus_ack(ack[0]), .o_spi_cs_n(cs_n[0]), .o_spi_sck(sck[0]),
        .o_spi_mosi(mosi[0]), .i_spi_miso(miso[0]), .o_dbg_state(dbg[0])
    );

    serv_ibus_spiflash #(.FLASH_OFFSET(24'h100000), .READ_CMD(CMD)) u_dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_ibus_adr(adr[1]), .i_ibus_cyc(cyc[1]),
        .o_ibus_rdt(rdt[1]), .o_ibus_ack(ack[1]), .o_spi_cs_n(cs_n[1]), .o_spi_sck(sck[1]),
        .o_spi_mosi(mosi[1]), .i_spi_miso(miso[1]), .o_dbg_state(dbg[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Flash memory contents: fixed boot word at 0x100, seeded hash elsewhere.
    function automatic logic [7:0] byte_at(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h13;
            24'h000101: return 8'h00;
            24'h000102: return 8'h00;
            24'h000103: return 8'h93;
            default:    return a[7:0] ^ (a[15:8] * 8'd3) ^ (a[23:16] * 8'd7) ^ mem_seed;
        endcase
    endfunction

    function automatic logic [23:0] flash_addr(input int ch, input logic [31:0] a);
        logic [23:0] off;
        off = (ch == 1) ? 24'h100000 : 24'h000000;
        return {a[23:2], 2'b00} + off;
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] f);
        return {byte_at(f + 24'd3), byte_at(f + 24'd2), byte_at(f + 24'd1), byte_at(f)};
    endfunction

    // Behavioural flash: captures cmd/addr on rising SCK, presents data for the current period.
    for (genvar g = 0; g < 2; g++) begin : g_flash
        int         d;
        logic [7:0] b;

        always @(negedge cs_n[g]) begin
            rises[g] = 0;
            seen[g]  = 32'd0;
        end

        always @(posedge sck[g]) begin
            if (cs_n[g]) begin
                spur_rises++;
            end else begin
                rises[g]++;
                if (rises[g] <= 32) begin
                    seen[g]  = {seen[g][30:0], mosi[g]};
                    miso[g]  = 1'($urandom_range(0, 1));
                end else begin
                    d        = rises[g] - 33;
                    b        = byte_at(seen[g][23:0] + 24'(d / 8));
                    miso[g]  = b[7 - (d % 8)];
                end
            end
        end

        always @(negedge clk) begin
            if (cs_n[g]) begin
                hi_cnt[g]++;
            end else begin
                if (hi_cnt[g] > 0) last_gap[g] = hi_cnt[g];
                hi_cnt[g] = 0;
            end
            if (sck[g]) begin
                sck_hi_run[g]++;
                if (sck_hi_run[g] > 1) sck_fast++;
            end else begin
                sck_hi_run[g] = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: one fetch on channel ch; keep_cyc leaves the request raised for a back-to-back fetch.
    task automatic do_fetch(input int ch, input logic [31:0] a, input bit keep_cyc, input bit chk_gap);
        logic [23:0] fa;
        logic [31:0] exp;
        int          n;
        bit          got;
        fa = flash_addr(ch, a);
        exp_q.push_back(word_at(fa));
        @(negedge clk);
        adr[ch] = a;
        cyc[ch] = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 2) adr[ch] = $urandom;
            if (ack[ch]) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        exp = exp_q.pop_front();
        if (got) begin
            check("ack_edge", n - 1, 32'd128);
            check("cs_n_at_ack", 32'(cs_n[ch]), 32'd1);
            check("sck_rises", rises[ch], 32'd64);
            check("mosi_cmd_addr", seen[ch], {CMD, fa});
            check("rdt", rdt[ch], exp);
            if (chk_gap) check("b2b_gap", last_gap[ch], 32'd2);
            if (!keep_cyc) cyc[ch] = 1'b0;
            @(posedge clk);
            #1;
            check("ack_pulse", 32'(ack[ch]), 32'd0);
            check("rdt_hold", rdt[ch], exp);
        end else begin
            cyc[ch] = 1'b0;
        end
    endtask

    task automatic do_abort(input int ch, input logic [31:0] a);
        logic [31:0] prev;
        int          ack_seen;
        prev = rdt[ch];
        @(negedge clk);
        adr[ch] = a;
        cyc[ch] = 1'b1;
        repeat (41) @(negedge clk);
        cyc[ch] = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs_n", 32'(cs_n[ch]), 32'd1);
        check("abort_sck", 32'(sck[ch]), 32'd0);
        ack_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[ch]) ack_seen++;
        end
        check("abort_no_ack", ack_seen, 32'd0);
        check("abort_rdt", rdt[ch], prev);
    endtask

    task automatic do_reset_mid(input int ch, input logic [31:0] a);
        @(negedge clk);
        adr[ch] = a;
        cyc[ch] = 1'b1;
        repeat (100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(cs_n[ch]), 32'd1);
        check("rst_sck", 32'(sck[ch]), 32'd0);
        check("rst_mosi", 32'(mosi[ch]), 32'd0);
        check("rst_ack", 32'(ack[ch]), 32'd0);
        check("rst_rdt", rdt[ch], 32'd0);
        cyc[ch] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        mem_seed = 8'($urandom);
        rst_n = 1'b0;
        cyc = 2'b00;
        adr[0] = 32'd0;
        adr[1] = 32'd0;
        miso = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rises[i] = 0;
            seen[i] = 32'd0;
            hi_cnt[i] = 0;
            last_gap[i] = 0;
            sck_hi_run[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_cs_n", 32'(cs_n[i]), 32'd1);
            check("reset_sck", 32'(sck[i]), 32'd0);
            check("reset_mosi", 32'(mosi[i]), 32'd0);
            check("reset_ack", 32'(ack[i]), 32'd0);
            check("reset_rdt", rdt[i], 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_fetch(0, 32'h0000_0100, 1'b0, 1'b0);
        check("boot_word", rdt[0], 32'h9300_0013);
        do_abort(0, 32'h0000_0200);
        check("abort_keeps_boot", rdt[0], 32'h9300_0013);
        do_fetch(0, 32'h0000_0200, 1'b0, 1'b0);
        do_fetch(1, 32'h0000_0004, 1'b0, 1'b0);
        do_fetch(1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        do_fetch(0, 32'hAB00_0107, 1'b0, 1'b0);

        do_fetch(0, 32'h0000_0100, 1'b1, 1'b0);
        do_fetch(0, $urandom, 1'b1, 1'b1);
        do_fetch(0, $urandom, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            do_fetch(int'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0);
        end

        do_reset_mid(0, $urandom);
        do_fetch(0, 32'h0000_0100, 1'b0, 1'b0);
        do_fetch(1, $urandom, 1'b0, 1'b0);

        check("spurious_sck", spur_rises, 32'd0);
        check("sck_rate", sck_fast, 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
